ff_sync_bank: RTL and testbench



---
 rtl/ff_sync_bank.sv | 88 ++++++++
 tb/tb_ff_sync_bank.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_sync_bank.sv
// ff_sync_bank: bank of independent multi-flop synchronizers that bring
// asynchronous single-bit flags into the clk domain. Each bit runs through a
// STAGES-deep chain, and a previous-value register provides single-cycle
// rise/fall pulses. All flops share one active edge, chosen by NEG_EDGE.
module ff_sync_bank #(
    parameter int WIDTH     = 1,
    parameter int STAGES    = 2,
    parameter bit NEG_EDGE  = 1'b0,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_async,
    output logic [WIDTH-1:0] out_sync,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall
);

    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

    // Depths below 2 give no metastability protection; depths above 4 only add latency.
    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("ff_sync_bank: STAGES must be in 2..4");
        end
    endgenerate

    // The chain flops must stay discrete registers placed close together: no
    // merging, retiming or shift-register (SRL) inference.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", preserve *)
    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    // Holds out_sync as it was one active edge earlier, for edge detection.
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // Shift path: stage 0 samples the raw input; every later stage copies its predecessor.
    always_comb begin
        sync_d[0] = in_async;
        for (int k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_q[STAGES-1];
    end

    generate
        if (NEG_EDGE) begin : g_neg
            // Falling-edge chain; rst is sampled on the falling edge only and beats any input change.
            always_ff @(negedge clk) begin
                if (rst) begin
                    for (int k = 0; k < STAGES; k++) begin
                        sync_q[k] <= RST_VEC;
                    end
                    prev_q <= RST_VEC;
                end else begin
                    for (int k = 0; k < STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                    prev_q <= prev_d;
                end
            end
        end else begin : g_pos
            // Rising-edge chain; rst is sampled on the rising edge only and beats any input change.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < STAGES; k++) begin
                        sync_q[k] <= RST_VEC;
                    end
                    prev_q <= RST_VEC;
                end else begin
                    for (int k = 0; k < STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                    prev_q <= prev_d;
                end
            end
        end
    endgenerate

    // Outputs are driven only from registers. During reset, out_sync and
    // prev_q both hold RESET_VAL, so neither pulse can fire. A bit can never
    // rise and fall in the same cycle.
    assign out_sync = sync_q[STAGES-1];
    assign out_rise = sync_q[STAGES-1] & ~prev_q;
    assign out_fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: tb/tb_ff_sync_bank.sv
// Testbench for ff_sync_bank.
// Four configurations share clk:
//   u_p  posedge, STAGES=2, RESET_VAL=0
//   u_n  negedge, STAGES=2, RESET_VAL=0
//   u_r  posedge, STAGES=2, RESET_VAL=1
//   u_w  posedge, WIDTH=4, STAGES=3
// A reference model built from per-edge input/reset logs predicts each output.
// A req/ack loop between two unrelated clocks exercises the 4-phase handshake.
`timescale 1ns/1ps
module tb_ff_sync_bank;

    logic clk = 1'b0;
    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    always #10 clk = ~clk;
    always #100 clk_a = ~clk_a;
    always #177.5 clk_b = ~clk_b;

    logic       rst;
    logic       in_a, in_r;
    logic [3:0] in_w;
    logic       p_sync, p_rise, p_fall;
    logic       n_sync, n_rise, n_fall;
    logic       r_sync, r_rise, r_fall;
    logic [3:0] w_sync, w_rise, w_fall;

    logic rst_ha, rst_hb, req, ack;
    logic req_sync, req_rise, req_fall;
    logic ack_sync, ack_rise, ack_fall;

    int checks = 0;
    int failures = 0;

    ff_sync_bank #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b0), .RESET_VAL(1'b0)) u_p (
        .clk(clk), .rst(rst), .in_async(in_a),
        .out_sync(p_sync), .out_rise(p_rise), .out_fall(p_fall));
    ff_sync_bank #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b1), .RESET_VAL(1'b0)) u_n (
        .clk(clk), .rst(rst), .in_async(in_a),
        .out_sync(n_sync), .out_rise(n_rise), .out_fall(n_fall));
    ff_sync_bank #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b0), .RESET_VAL(1'b1)) u_r (
        .clk(clk), .rst(rst), .in_async(in_r),
        .out_sync(r_sync), .out_rise(r_rise), .out_fall(r_fall));
    ff_sync_bank #(.WIDTH(4), .STAGES(3), .NEG_EDGE(1'b0), .RESET_VAL(1'b0)) u_w (
        .clk(clk), .rst(rst), .in_async(in_w),
        .out_sync(w_sync), .out_rise(w_rise), .out_fall(w_fall));

    // Handshake: req crosses into the clk_b domain (posedge), ack crosses back into the clk_a domain (negedge).
    ff_sync_bank #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b0), .RESET_VAL(1'b0)) u_hreq (
        .clk(clk_b), .rst(rst_hb), .in_async(req),
        .out_sync(req_sync), .out_rise(req_rise), .out_fall(req_fall));
    ff_sync_bank #(.WIDTH(1), .STAGES(2), .NEG_EDGE(1'b1), .RESET_VAL(1'b0)) u_hack (
        .clk(clk_a), .rst(rst_ha), .in_async(ack),
        .out_sync(ack_sync), .out_rise(ack_rise), .out_fall(ack_fall));

    // Per-edge logs: the input seen at each active edge, and the most recent
    // edge at which reset was sampled. Edge 0 stands for a reset.
    logic [3:0] pa [0:4095];
    logic [3:0] pr [0:4095];
    logic [3:0] pw [0:4095];
    bit         prs [0:4095];
    int         plr [0:4095];
    int         pn = 0;
    logic [3:0] na [0:4095];
    bit         nrs [0:4095];
    int         nlr [0:4095];
    int         nn = 0;

    initial begin
        plr[0] = 0;
        prs[0] = 1'b1;
        forever begin
            @(posedge clk);
            if (pn < 4095) begin
                pn = pn + 1;
                pa[pn]  = {3'b000, in_a};
                pr[pn]  = {3'b000, in_r};
                pw[pn]  = in_w;
                prs[pn] = rst;
                plr[pn] = rst ? pn : plr[pn-1];
            end
        end
    end

    initial begin
        nlr[0] = 0;
        nrs[0] = 1'b1;
        forever begin
            @(negedge clk);
            if (nn < 4095) begin
                nn = nn + 1;
                na[nn]  = {3'b000, in_a};
                nrs[nn] = rst;
                nlr[nn] = rst ? nn : nlr[nn-1];
            end
        end
    end

    // Expected level after posedge n. If at least s edges have passed since
    // the last reset, the output shows the input sampled at edge n-s+1;
    // otherwise it shows the reset value.
    // kind: 0 = u_p, 1 = u_r, 2 = u_w.
    function automatic logic [3:0] pexp(input int kind, input int n);
        int s;
        logic [3:0] rv;
        s  = (kind == 2) ? 3 : 2;
        rv = (kind == 1) ? 4'h1 : 4'h0;
        if (n <= 0) return rv;
        if (n - plr[n] < s) return rv;
        case (kind)
            0:       return pa[n-s+1];
            1:       return pr[n-s+1];
            default: return pw[n-s+1];
        endcase
    endfunction

    function automatic logic [3:0] pprev(input int kind, input int n);
        if (n <= 0 || prs[n]) return (kind == 1) ? 4'h1 : 4'h0;
        return pexp(kind, n - 1);
    endfunction

    function automatic logic [3:0] nexp(input int n);
        if (n <= 0) return 4'h0;
        if (n - nlr[n] < 2) return 4'h0;
        return na[n-1];
    endfunction

    function automatic logic [3:0] nprev(input int n);
        if (n <= 0 || nrs[n]) return 4'h0;
        return nexp(n - 1);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pos();
        logic [3:0] e, p;
        e = pexp(0, pn); p = pprev(0, pn);
        check("p_sync", {3'b000, p_sync}, e & 4'h1);
        check("p_rise", {3'b000, p_rise}, e & ~p & 4'h1);
        check("p_fall", {3'b000, p_fall}, ~e & p & 4'h1);
        e = pexp(1, pn); p = pprev(1, pn);
        check("r_sync", {3'b000, r_sync}, e & 4'h1);
        check("r_rise", {3'b000, r_rise}, e & ~p & 4'h1);
        check("r_fall", {3'b000, r_fall}, ~e & p & 4'h1);
        e = pexp(2, pn); p = pprev(2, pn);
        check("w_sync", w_sync, e);
        check("w_rise", w_rise, e & ~p);
        check("w_fall", w_fall, ~e & p);
        check("w_excl", w_rise & w_fall, 4'h0);
        check("n_hold_on_posedge", {3'b000, n_sync}, nexp(nn) & 4'h1);
    endtask

    task automatic check_neg();
        logic [3:0] e, p;
        e = nexp(nn); p = nprev(nn);
        check("n_sync", {3'b000, n_sync}, e & 4'h1);
        check("n_rise", {3'b000, n_rise}, e & ~p & 4'h1);
        check("n_fall", {3'b000, n_fall}, ~e & p & 4'h1);
    endtask

    task automatic step();
        @(posedge clk); #1;
        check_pos();
        @(negedge clk); #1;
        check_neg();
    endtask

    int b_rise_cnt = 0;
    int b_fall_cnt = 0;
    int a_rise_cnt = 0;

    // clk_b side of the handshake: raise ack on a synchronized req rise, drop it on a req fall.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk_b); #1;
            if (!rst_hb) begin
                if (req_rise) begin b_rise_cnt++; ack = 1'b1; end
                if (req_fall) begin b_fall_cnt++; ack = 1'b0; end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_a); #1;
            if (!rst_ha && ack_rise) a_rise_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] got;
        int rise_cnt;
        rst = 1'b1; in_a = 1'b0; in_r = 1'b0; in_w = 4'h0;
        req = 1'b0; rst_ha = 1'b1; rst_hb = 1'b1;

        // Reset held for three cycles.
        repeat (3) step();
        check("rst_p_sync", {3'b000, p_sync}, 4'h0);
        check("rst_p_rise", {3'b000, p_rise}, 4'h0);
        check("rst_r_sync", {3'b000, r_sync}, 4'h1);
        check("rst_r_fall", {3'b000, r_fall}, 4'h0);
        check("rst_n_sync", {3'b000, n_sync}, 4'h0);

        // Release reset with in_a=1 and in_r=0 already settled.
        rst = 1'b0; in_a = 1'b1;
        step();
        check("lat1_p_sync", {3'b000, p_sync}, 4'h0);
        check("lat1_r_sync", {3'b000, r_sync}, 4'h1);
        check("lat1_n_sync", {3'b000, n_sync}, 4'h0);
        step();
        check("lat2_p_sync", {3'b000, p_sync}, 4'h1);
        check("lat2_p_rise", {3'b000, p_rise}, 4'h1);
        check("lat2_p_fall", {3'b000, p_fall}, 4'h0);
        check("lat2_r_sync", {3'b000, r_sync}, 4'h0);
        check("lat2_r_fall", {3'b000, r_fall}, 4'h1);
        check("lat2_n_sync", {3'b000, n_sync}, 4'h1);
        check("lat2_n_rise", {3'b000, n_rise}, 4'h1);
        step();
        check("lat3_p_rise", {3'b000, p_rise}, 4'h0);
        check("lat3_r_fall", {3'b000, r_fall}, 4'h0);
        check("lat3_n_rise", {3'b000, n_rise}, 4'h0);

        // Reset arrives while a 1 is still inside the chain.
        in_a = 1'b0;
        repeat (4) step();
        in_a = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("midrst_p_sync", {3'b000, p_sync}, 4'h0);
        check("midrst_n_sync", {3'b000, n_sync}, 4'h0);
        rst = 1'b0;
        rise_cnt = 0;
        repeat (5) begin
            step();
            rise_cnt += int'(p_rise);
        end
        check("midrst_p_sync_after", {3'b000, p_sync}, 4'h1);
        check("midrst_rise_count", 4'(rise_cnt), 4'h1);

        // Alternating pattern on the 4-bit instance: a new value every cycle.
        in_w = 4'b0101;
        repeat (12) begin
            step();
            in_w = ~in_w;
        end

        // Random inputs with occasional reset pulses.
        repeat (80) begin
            in_a = 1'($urandom_range(0, 1));
            in_r = 1'($urandom_range(0, 1));
            in_w = 4'($urandom);
            rst  = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        // 4-phase req/ack handshake between the two unrelated clocks.
        @(posedge clk_b); #1; rst_hb = 1'b0;
        @(negedge clk_a); #1; rst_ha = 1'b0;
        repeat (4) @(negedge clk_a);
        #1;
        for (int i = 0; i < 5; i++) begin
            req = 1'b1;
            got = 4'h0;
            for (int c = 0; c < 40 && got == 4'h0; c++) begin
                @(negedge clk_a); #1;
                if (ack_sync) got = 4'h1;
            end
            check("hs_ack_seen", got, 4'h1);
            req = 1'b0;
            got = 4'h0;
            for (int c = 0; c < 40 && got == 4'h0; c++) begin
                @(negedge clk_a); #1;
                if (!ack_sync) got = 4'h1;
            end
            check("hs_ack_dropped", got, 4'h1);
        end
        repeat (6) @(negedge clk_a);
        #1;
        check("hs_req_rise_count", 4'(b_rise_cnt), 4'h5);
        check("hs_req_fall_count", 4'(b_fall_cnt), 4'h5);
        check("hs_ack_rise_count", 4'(a_rise_cnt), 4'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
